instr_encoder: RTL

Instruction encoder and instruction-memory loader for the single-cycle MIPS CPU. It performs the inverse of the control decoder: it accepts symbolic instructions (mnemonic code plus register, shift, immediate and target fields) over a valid/ready handshake and assembles each into a 32-bit MIPS word. Each word is written to consecutive instruction-memory locations starting at the text base. The block preloads test programs into IM before the CPU is released from reset.

---
 rtl/instr_pkg.sv | 76 +++++++
 rtl/instr_pack.sv | 42 ++++
 rtl/instr_encoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - mnemonic codes, MIPS opcode/funct values, field positions and word builders
package instr_pkg;

    // Mnemonic codes accepted on in_op; 16..31 are illegal.
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLLV = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd4;
    localparam logic [4:0] OP_JR   = 5'd5;
    localparam logic [4:0] OP_ORI  = 5'd6;
    localparam logic [4:0] OP_LW   = 5'd7;
    localparam logic [4:0] OP_SW   = 5'd8;
    localparam logic [4:0] OP_BEQ  = 5'd9;
    localparam logic [4:0] OP_LUI  = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_J    = 5'd12;
    localparam logic [4:0] OP_JAL  = 5'd13;
    localparam logic [4:0] OP_SB   = 5'd14;
    localparam logic [4:0] OP_LB   = 5'd15;

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SB    = 6'b101000;
    localparam logic [5:0] OPC_LB    = 6'b100000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    // R-type funct values
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // Field LSB positions within the 32-bit word
    localparam int OP_LSB  = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SH_LSB  = 6;
    localparam int FN_LSB  = 0;
    localparam int IMM_LSB = 0;
    localparam int TGT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return (32'(OPC_RTYPE) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
             | (32'(rd) << RD_LSB) | (32'(sh) << SH_LSB) | (32'(fn) << FN_LSB);
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return (32'(opc) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
             | (32'(imm) << IMM_LSB);
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] target);
        return (32'(opc) << OP_LSB) | (32'(target) << TGT_LSB);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational mnemonic-to-MIPS-word mapper
// Ports: op/rs/rt/rd/shamt/imm/target in; word (encoded instruction) and legal (op 0..15) out.
module instr_pack
    import instr_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Fields an encoding does not use are passed as zero so they never leak into the word.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op)
            OP_ADD:  word = r_word(rs, rt, rd, 5'd0, FN_ADD);
            OP_SUB:  word = r_word(rs, rt, rd, 5'd0, FN_SUB);
            OP_SLL:  word = r_word(5'd0, rt, rd, shamt, FN_SLL);
            OP_SLLV: word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
            OP_SLT:  word = r_word(rs, rt, rd, 5'd0, FN_SLT);
            OP_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            OP_ORI:  word = i_word(OPC_ORI, rs, rt, imm);
            OP_LW:   word = i_word(OPC_LW, rs, rt, imm);
            OP_SW:   word = i_word(OPC_SW, rs, rt, imm);
            OP_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
            OP_LUI:  word = i_word(OPC_LUI, 5'd0, rt, imm);
            OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
            OP_J:    word = j_word(OPC_J, target);
            OP_JAL:  word = j_word(OPC_JAL, target);
            OP_SB:   word = i_word(OPC_SB, rs, rt, imm);
            OP_LB:   word = i_word(OPC_LB, rs, rt, imm);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - symbolic instruction encoder and instruction-memory loader
// Ports: clk, reset (async high); start/finish session control; in_valid/in_ready handshake
// with in_op/in_rs/in_rt/in_rd/in_shamt/in_imm/in_target fields; im_we/im_addr/im_wdata
// memory write port; count/full/busy/done/err status.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE       = 32'h0000_3000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_op,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    output logic                  im_we,
    output logic [31:0]           im_addr,
    output logic [31:0]           im_wdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [DEPTH_LOG2:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t      state, state_nxt;
    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic        session_start;

    instr_pack u_pack (
        .op     (in_op),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .imm    (in_imm),
        .target (in_target),
        .word   (word),
        .legal  (legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)  state_nxt = ST_LOAD;
            ST_LOAD: if (finish) state_nxt = ST_DONE;
            ST_DONE: if (start)  state_nxt = ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_LOAD);
        done     = (state == ST_DONE);
        full     = (count == CAPACITY);
        in_ready = busy & ~full;
    end

    assign accept        = in_valid & in_ready;
    assign session_start = start & (state != ST_LOAD);

    // count advances on the accepting edge so it is visible together with the im_we pulse;
    // the write address is taken from the pre-increment count, i.e. the slot index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_we    <= 1'b0;
            im_addr  <= BASE;
            im_wdata <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            im_we <= 1'b0;
            if (session_start) begin
                count <= '0;
                err   <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    im_we    <= 1'b1;
                    im_wdata <= word;
                    im_addr  <= BASE + (32'(count) << 2);
                    count    <= count + 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
